scan_ctrl: RTL
==============

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, scan chain length in flops (2..256).
REQ-002 SHALL have parameter NPAT_W, default 8, width of the pattern-count input.
REQ-003 SHALL have port C, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port global_reset, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port start, input, 1, begins a test session when in IDLE.
REQ-006 SHALL have port abort, input, 1, terminates any session.
REQ-007 SHALL have port num_pat, input, NPAT_W, pattern count, latched on accepted start.
REQ-008 SHALL have ports pat_valid (in, 1), pat_ready (out, 1), pat_data (in, CHAIN_LEN): the pattern handshake.
REQ-009 SHALL have port So, input, 1, scan-out from the last chain flop.
REQ-010 SHALL have ports NbarT (out, 1), Si (out, 1), CE (out, 1), driving the dff NbarT/Si/CE pins of the chain.
REQ-011 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, CHAIN_LEN): the response handshake.
REQ-012 SHALL have ports busy (out, 1), done (out, 1), signature (out, 16).

Function
REQ-013 SHALL implement the states IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, HOLD.
REQ-014 IDLE: start=1 latches num_pat and enters LOAD; num_pat=0 instead pulses done for 1 cycle and stays in IDLE.
REQ-015 LOAD: pat_ready=1; a pat_valid&pat_ready transfer copies pat_data into the shift register and enters SHIFT on the next cycle.
REQ-016 SHIFT: lasts exactly CHAIN_LEN cycles with NbarT=1 and CE=0; each cycle Si = bit 0 of the shift register, the shift register shifts right, and So is shifted into the response register MSB-first-in.
REQ-017 After SHIFT, rsp_data[0] SHALL hold the first So bit sampled and rsp_data[CHAIN_LEN-1] the last.
REQ-018 CAPTURE: exactly 1 cycle with NbarT=0, CE=1 and Si=0; then LOAD if patterns remain, else UNLOAD.
REQ-019 The response shifted out during the first pattern's SHIFT SHALL be discarded (no rsp_valid); every later SHIFT and the UNLOAD shift SHALL raise rsp_valid on the cycle after their last shift cycle.
REQ-020 UNLOAD: CHAIN_LEN cycles, NbarT=1, Si=0, capturing So as in SHIFT; done pulses 1 cycle when its response is accepted, then IDLE.
REQ-021 rsp_valid SHALL hold with rsp_data stable until rsp_ready=1.
REQ-022 HOLD: if a new response would complete while rsp_valid&!rsp_ready, the FSM SHALL wait in HOLD (NbarT=0, CE=0, chain frozen) before starting that shift, and resume when the handshake completes.
REQ-023 Exactly num_pat responses per session; busy=1 in every state except IDLE.
REQ-024 abort SHALL force IDLE on the next edge, with NbarT=0, CE=0, rsp_valid=0, no done pulse; abort wins over start in the same cycle.
REQ-025 start while busy SHALL be ignored.

Reset
REQ-026 global_reset SHALL yield state IDLE and NbarT=0, Si=0, CE=0, pat_ready=0, rsp_valid=0, rsp_data=0, busy=0, done=0, signature=0, counters=0; it overrides abort/start and applies mid-session.

Configuration
REQ-027 With SCAN_MISR_EN defined, signature SHALL be a 16-bit MISR, cleared on accepted start, folding each So bit that belongs to a counted response (polynomial x^16+x^12+x^5+1).
REQ-028 Without SCAN_MISR_EN, signature SHALL be constant 0 and no MISR logic SHALL exist.

Structure
REQ-029 A package scan_ctrl_pkg SHALL hold the state enum typedef, the MISR polynomial constant, and the signature width constant (16).
REQ-030 The MISR SHALL be the sub-module scan_misr, instantiated only under SCAN_MISR_EN.

Verification
REQ-031 CHAIN_LEN=4, num_pat=2, patterns 4'b1010 then 4'b0110, chain modelled as 4 dffs -> Si sequence 0,1,0,1 then 0,1,1,0; exactly 2 responses; done pulses once.
REQ-032 Loopback chain (So = Si delayed 4 cycles), CAPTURE D=~Q -> rsp_data equals bitwise inverse of the previous pattern.
REQ-033 rsp_ready held 0 for 10 cycles after the first rsp_valid -> FSM in HOLD with NbarT=0 throughout, rsp_data stable, no extra Si toggles.
REQ-034 num_pat=0 with start -> done=1 for 1 cycle, busy stays 0, NbarT never asserted.
REQ-035 abort during shift cycle 2 of 4 -> next cycle IDLE, NbarT=0, no rsp_valid; a later start runs normally.
REQ-036 SCAN_MISR_EN, 3 patterns of all-ones on a loopback chain -> signature matches the reference-model MISR value; global_reset mid-session clears it to 0.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test controller.
//   state_t   : controller FSM encoding
//   SIG_W     : signature width
//   MISR_POLY : MISR feedback taps for x^16+x^12+x^5+1 (x^16 term implicit)
package scan_ctrl_pkg;

  localparam int unsigned SIG_W = 16;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    HOLD    = 3'd5
  } state_t;

endpackage

// File: rtl/scan_misr.sv
// Serial-input 16-bit MISR that folds one scan-out bit per enabled cycle.
// Ports:
//   C            : clock
//   global_reset : synchronous active-high reset
//   clr          : synchronous clear (new session)
//   en           : fold din this cycle
//   din          : scan-out bit
//   sig          : current signature
module scan_misr
  import scan_ctrl_pkg::*;
(
  input  logic             C,
  input  logic             global_reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic fb;

  assign fb = sig[SIG_W-1] ^ din;

  // Shift left, XOR taps in when the outgoing bit differs from the input bit
  always_ff @(posedge C) begin
    if (global_reset || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Scan test controller: loads patterns into a scan chain, pulses capture,
// and streams responses out through a valid/ready handshake.
// Optional feature: define SCAN_MISR_EN to compact counted responses into a
// 16-bit MISR on `signature`; otherwise `signature` is tied to 0.
// Ports:
//   C, global_reset          : clock, synchronous active-high reset
//   start, abort, num_pat    : session control and pattern count
//   pat_valid/ready/data     : pattern input handshake
//   So                       : scan-out from the last chain flop
//   NbarT, Si, CE            : chain test-mode, scan-in, capture-enable
//   rsp_valid/ready/data     : response output handshake
//   busy, done, signature    : status
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned NPAT_W    = 8
) (
  input  logic                 C,
  input  logic                 global_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NPAT_W-1:0]    num_pat,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 So,
  output logic                 NbarT,
  output logic                 Si,
  output logic                 CE,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_W-1:0]     signature
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN);

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] shreg_q;
  logic [CHAIN_LEN-2:0] cap_q;
  logic [CHAIN_LEN-1:0] cap_next;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [NPAT_W-1:0]    pat_left_q;
  logic                 first_q;     // current shift carries the discarded power-up response
  logic                 unl_wait_q;  // unload shifted, waiting for its response to drain
  logic                 hold_unl_q;  // HOLD resumes into UNLOAD rather than SHIFT
  logic                 last_bit;
  logic                 rsp_pending;

  assign cap_next    = {So, cap_q};
  assign last_bit    = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign rsp_pending = rsp_valid & ~rsp_ready;

  // State register
  always_ff @(posedge C) begin
    if (global_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (num_pat != '0)) state_d = LOAD;
      LOAD:    if (pat_valid) state_d = rsp_pending ? HOLD : SHIFT;
      SHIFT:   if (last_bit) state_d = CAPTURE;
      CAPTURE: begin
        if (pat_left_q != '0) state_d = LOAD;
        else                  state_d = rsp_pending ? HOLD : UNLOAD;
      end
      UNLOAD:  if (unl_wait_q && rsp_valid && rsp_ready) state_d = IDLE;
      HOLD:    if (!rsp_pending) state_d = hold_unl_q ? UNLOAD : SHIFT;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Chain-side outputs decoded from state
  always_comb begin
    NbarT     = 1'b0;
    Si        = 1'b0;
    CE        = 1'b0;
    pat_ready = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      LOAD:    pat_ready = 1'b1;
      SHIFT: begin
        NbarT = 1'b1;
        Si    = shreg_q[0];
      end
      CAPTURE: CE = 1'b1;
      UNLOAD:  NbarT = ~unl_wait_q;
      default: ;
    endcase
  end

  // Datapath: shift/response registers, counters and handshake state
  always_ff @(posedge C) begin
    if (global_reset) begin
      shreg_q    <= '0;
      cap_q      <= '0;
      bit_cnt_q  <= '0;
      pat_left_q <= '0;
      first_q    <= 1'b0;
      unl_wait_q <= 1'b0;
      hold_unl_q <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        rsp_valid  <= 1'b0;
        bit_cnt_q  <= '0;
        unl_wait_q <= 1'b0;
      end else begin
        if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
        case (state_q)
          IDLE: begin
            if (start) begin
              if (num_pat == '0) done <= 1'b1;
              pat_left_q <= num_pat;
              first_q    <= 1'b1;
              bit_cnt_q  <= '0;
              unl_wait_q <= 1'b0;
            end
          end
          LOAD: begin
            if (pat_valid) begin
              shreg_q    <= pat_data;
              pat_left_q <= pat_left_q - NPAT_W'(1);
              hold_unl_q <= 1'b0;
            end
          end
          SHIFT: begin
            shreg_q   <= {1'b0, shreg_q[CHAIN_LEN-1:1]};
            cap_q     <= cap_next[CHAIN_LEN-1:1];
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              bit_cnt_q <= '0;
              first_q   <= 1'b0;
              if (!first_q) begin
                rsp_valid <= 1'b1;
                rsp_data  <= cap_next;
              end
            end
          end
          CAPTURE: hold_unl_q <= (pat_left_q == '0);
          UNLOAD: begin
            if (!unl_wait_q) begin
              cap_q     <= cap_next[CHAIN_LEN-1:1];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (last_bit) begin
                bit_cnt_q  <= '0;
                unl_wait_q <= 1'b1;
                rsp_valid  <= 1'b1;
                rsp_data   <= cap_next;
              end
            end else if (rsp_valid && rsp_ready) begin
              done       <= 1'b1;
              unl_wait_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SCAN_MISR_EN
  logic misr_clr;
  logic misr_en;

  // Only bits of counted responses are folded; the power-up shift is skipped
  assign misr_clr = (state_q == IDLE) && start && !abort;
  assign misr_en  = !abort && (((state_q == SHIFT) && !first_q) ||
                               ((state_q == UNLOAD) && !unl_wait_q));

  scan_misr u_misr (
    .C            (C),
    .global_reset (global_reset),
    .clr          (misr_clr),
    .en           (misr_en),
    .din          (So),
    .sig          (signature)
  );
`else
  assign signature = '0;
`endif

endmodule
